instr_issue_sequencer: RTL and testbench

//  Multi-cycle fetch/issue controller in front of the dual-ISA (ARM/RISC-V) control unit. Owns PC and ISA mode,

---
 rtl/instr_issue_sequencer_pkg.sv | 46 ++++
 rtl/instr_issue_sequencer_seq_pc_unit.sv | 36 +++
 rtl/instr_issue_sequencer.sv | 160 ++++++++++++++++
 tb/tb_instr_issue_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issue_sequencer_pkg.sv
// Shared types and constants for the fetch/issue sequencer in front of the dual-ISA control unit.
package instr_issue_sequencer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OFF_W  = 8;
    localparam int unsigned RET_W  = 16;
    localparam int unsigned TMO_W  = 4;

    localparam logic [WORD_W-1:0] ISA_SEL_ARM = 32'h0000_0000;
    localparam logic [WORD_W-1:0] ISA_SEL_RV  = 32'h0000_0001;
    localparam logic [WORD_W-1:0] HALT_WORD   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALTED   = 3'd4,
        ST_ERROR    = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_RESET  = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        WK_INSTR   = 2'd0,
        WK_ISA_ARM = 2'd1,
        WK_ISA_RV  = 2'd2,
        WK_HALT    = 2'd3
    } word_kind_t;

    // Classify a fetched word: sequencer control words are consumed, everything else is issued.
    function automatic word_kind_t word_kind(input logic [WORD_W-1:0] w);
        word_kind_t k;
        k = WK_INSTR;
        if (w == ISA_SEL_ARM)     k = WK_ISA_ARM;
        else if (w == ISA_SEL_RV) k = WK_ISA_RV;
        else if (w == HALT_WORD)  k = WK_HALT;
        return k;
    endfunction

endpackage

// File: rtl/instr_issue_sequencer_seq_pc_unit.sv
// Program counter register: hold, +1, +1+sext(offset) or reload, all modulo 2^PC_W.
module seq_pc_unit
    import instr_issue_sequencer_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_sel,
    input  logic [OFF_W-1:0]  br_offset,
    output logic [PC_W-1:0]   pc
);

    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_nx;

    // Signed cast sign-extends the branch offset to the PC width.
    assign off_ext = PC_W'($signed(br_offset));

    always_comb begin
        pc_nx = pc;
        case (pc_sel)
            PC_INC:    pc_nx = pc + PC_W'(1);
            PC_BRANCH: pc_nx = pc + PC_W'(1) + off_ext;
            PC_RESET:  pc_nx = PC_W'(RESET_PC);
            default:   pc_nx = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) pc <= PC_W'(RESET_PC);
        else     pc <= pc_nx;
    end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Multi-cycle fetch/issue controller: owns PC and ISA mode, fetches over imem req/ack,
// issues one instruction per ISSUE cycle, stalls on data memory with a bounded wait.
module instr_issue_sequencer
    import instr_issue_sequencer_pkg::*;
#(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              isa_riscv,
    input  logic              dec_is_branch,
    input  logic              br_taken,
    input  logic [7:0]        br_offset,
    input  logic              dec_is_mem,
    input  logic              dmem_ack,
    output logic [15:0]       retired,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    seq_state_t        state;
    seq_state_t        state_nx;
    pc_sel_t           pc_sel;
    word_kind_t        kind;
    logic              load_instr;
    logic              isa_load;
    logic              isa_nx;
    logic              retire_inc;
    logic              tmo_clr;
    logic              tmo_inc;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [PC_W-1:0]   pc;

    assign kind      = word_kind(imem_data);
    assign imem_addr = pc;

    seq_pc_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .pc_sel    (pc_sel),
        .br_offset (br_offset),
        .pc        (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state and datapath controls.
    always_comb begin
        state_nx   = state;
        pc_sel     = PC_HOLD;
        load_instr = 1'b0;
        isa_load   = 1'b0;
        isa_nx     = isa_riscv;
        retire_inc = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    case (kind)
                        WK_ISA_ARM: begin
                            isa_load = 1'b1;
                            isa_nx   = 1'b0;
                            pc_sel   = PC_INC;
                        end
                        WK_ISA_RV: begin
                            isa_load = 1'b1;
                            isa_nx   = 1'b1;
                            pc_sel   = PC_INC;
                        end
                        WK_HALT:  state_nx = ST_HALTED;
                        default:  state_nx = ST_ISSUE;
                    endcase
                end
            end
            ST_ISSUE: begin
                retire_inc = 1'b1;
                state_nx   = ST_FETCH;
                // A memory op stalls even if the decoder also flags a branch.
                if (dec_is_mem) begin
                    state_nx = ST_MEM_WAIT;
                    tmo_clr  = 1'b1;
                end else if (dec_is_branch && br_taken) begin
                    pc_sel = PC_BRANCH;
                end else begin
                    pc_sel = PC_INC;
                end
            end
            ST_MEM_WAIT: begin
                // An ack on the last counted cycle still completes the access.
                if (dmem_ack) begin
                    pc_sel   = PC_INC;
                    state_nx = ST_FETCH;
                end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
                    state_nx = ST_ERROR;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    pc_sel   = PC_RESET;
                    isa_load = 1'b1;
                    isa_nx   = 1'b0;
                    state_nx = ST_FETCH;
                end
            end
            ST_ERROR: state_nx = ST_ERROR;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Datapath registers; status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= '0;
            isa_riscv   <= 1'b0;
            retired     <= '0;
            tmo_cnt     <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (load_instr) instr <= imem_data;
            if (isa_load)   isa_riscv <= isa_nx;
            if (retire_inc) retired <= retired + RET_W'(1);
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);
            imem_req    <= (state_nx == ST_FETCH);
            instr_valid <= (state_nx == ST_ISSUE);
            busy        <= (state_nx == ST_FETCH) || (state_nx == ST_ISSUE)
                           || (state_nx == ST_MEM_WAIT);
            halted      <= (state_nx == ST_HALTED);
            err         <= (state_nx == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Self-checking bench for instr_issue_sequencer: directed sequences, a branch vector table
// and a randomized run against an instruction-level reference model.
module tb_instr_issue_sequencer;

    localparam logic [31:0] ALU_A = 32'h0000_0013;
    localparam logic [31:0] ALU_B = 32'h00A0_0093;
    localparam logic [31:0] ALU_C = 32'hE082_1003;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        isa_riscv;
    logic        dec_is_branch;
    logic        br_taken;
    logic [7:0]  br_offset;
    logic        dec_is_mem;
    logic        dmem_ack;
    logic [15:0] retired;
    logic        busy;
    logic        halted;
    logic        err;

    int          total;
    int          bad;
    int unsigned cyc;

    instr_issue_sequencer #(
        .PC_W        (8),
        .RESET_PC    (0),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .isa_riscv     (isa_riscv),
        .dec_is_branch (dec_is_branch),
        .br_taken      (br_taken),
        .br_offset     (br_offset),
        .dec_is_mem    (dec_is_mem),
        .dmem_ack      (dmem_ack),
        .retired       (retired),
        .busy          (busy),
        .halted        (halted),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rst = 0; start = 0; imem_ack = 0; imem_data = '0;
        dec_is_branch = 0; br_taken = 0; br_offset = '0; dec_is_mem = 0; dmem_ack = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic run_start();
        start = 1;
        step();
        start = 0;
    endtask

    // Wait (bounded) for a fetch request, then return the word with zero wait.
    task automatic feed(input logic [31:0] w);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("feed_req", imem_req, 1'b1);
        imem_ack  = 1;
        imem_data = w;
        step();
        imem_ack  = 0;
        imem_data = $urandom;
    endtask

    typedef struct {
        logic       mem;
        logic       br;
        logic       tk;
        logic [7:0] off;
        logic [7:0] exp_addr;
    } br_vec_t;

    br_vec_t vt[7];

    // Reference model state for the randomized run.
    typedef enum int {P_IDLE, P_FETCH, P_ISSUE, P_MEM, P_HALT, P_ERR} phase_t;
    phase_t      m_phase;
    logic [7:0]  m_pc;
    logic        m_isa;
    logic [15:0] m_ret;
    logic [31:0] m_instr;
    int          m_wait;
    logic [31:0] prog[256];

    task automatic model_reset();
        m_phase = P_IDLE; m_pc = 8'd0; m_isa = 0; m_ret = '0; m_instr = '0; m_wait = 0;
    endtask

    task automatic check_model();
        chk("r_req",     imem_req,    m_phase == P_FETCH);
        chk("r_valid",   instr_valid, m_phase == P_ISSUE);
        chk("r_busy",    busy,        m_phase == P_FETCH || m_phase == P_ISSUE || m_phase == P_MEM);
        chk("r_halted",  halted,      m_phase == P_HALT);
        chk("r_err",     err,         m_phase == P_ERR);
        chk("r_isa",     isa_riscv,   m_isa);
        chk("r_retired", retired,     m_ret);
        chk("r_instr",   instr,       m_instr);
        if (m_phase == P_FETCH) chk("r_addr", imem_addr, m_pc);
    endtask

    initial begin
        int t0, t1, t2;
        int tt;
        total = 0;
        bad   = 0;
        clear_in();

        vt[0] = '{mem: 0, br: 1, tk: 1, off: 8'hFB, exp_addr: 8'd254};
        vt[1] = '{mem: 0, br: 1, tk: 0, off: 8'hFB, exp_addr: 8'd3};
        vt[2] = '{mem: 1, br: 1, tk: 1, off: 8'hFB, exp_addr: 8'd3};
        vt[3] = '{mem: 0, br: 1, tk: 1, off: 8'd10, exp_addr: 8'd13};
        vt[4] = '{mem: 0, br: 1, tk: 1, off: 8'h80, exp_addr: 8'd131};
        vt[5] = '{mem: 0, br: 1, tk: 1, off: 8'h7F, exp_addr: 8'd130};
        vt[6] = '{mem: 0, br: 0, tk: 1, off: 8'h40, exp_addr: 8'd3};

        // Reset state
        do_reset();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        chk("rst_isa", isa_riscv, 0);
        chk("rst_retired", retired, 0);
        chk("rst_instr", instr, 0);

        // Straight-line: three ALU words, two cycles each
        run_start();
        chk("sl_addr0", imem_addr, 0);
        feed(ALU_A); chk("sl_v0", instr_valid, 1); t0 = int'(cyc); step();
        feed(ALU_B); chk("sl_v1", instr_valid, 1); t1 = int'(cyc); step();
        feed(ALU_C); chk("sl_v2", instr_valid, 1); t2 = int'(cyc);
        chk("sl_instr", instr, ALU_C);
        step();
        chk("sl_gap1", 32'(t1 - t0), 2);
        chk("sl_gap2", 32'(t2 - t1), 2);
        chk("sl_retired", retired, 3);
        chk("sl_addr3", imem_addr, 3);
        chk("sl_req", imem_req, 1);

        // Mode switch words are consumed without issue
        do_reset();
        run_start();
        feed(32'h1);
        chk("ms_isa1", isa_riscv, 1);
        chk("ms_stay_fetch", imem_req, 1);
        chk("ms_addr1", imem_addr, 1);
        chk("ms_novalid", instr_valid, 0);
        feed(ALU_A);
        chk("ms_valid", instr_valid, 1);
        step();
        feed(32'h0);
        chk("ms_isa0", isa_riscv, 0);
        chk("ms_addr3", imem_addr, 3);
        chk("ms_retired", retired, 1);

        // Branch vector table: issue at pc=2
        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_start();
            feed(32'h0);
            feed(32'h0);
            feed(ALU_B);
            chk($sformatf("bt%0d_valid", i), instr_valid, 1);
            dec_is_mem = vt[i].mem; dec_is_branch = vt[i].br;
            br_taken = vt[i].tk; br_offset = vt[i].off;
            step();
            clear_in();
            if (vt[i].mem) begin
                chk($sformatf("bt%0d_memwait", i), imem_req, 0);
                dmem_ack = 1;
                step();
                dmem_ack = 0;
            end
            chk($sformatf("bt%0d_req", i), imem_req, 1);
            chk($sformatf("bt%0d_addr", i), imem_addr, vt[i].exp_addr);
        end

        // Load stall, ack after 4 wait cycles
        do_reset(); run_start(); feed(ALU_A);
        dec_is_mem = 1; step(); dec_is_mem = 0;
        chk("ld_req0", imem_req, 0);
        chk("ld_busy", busy, 1);
        repeat (4) step();
        chk("ld_noerr", err, 0);
        dmem_ack = 1; step(); dmem_ack = 0;
        chk("ld_req", imem_req, 1);
        chk("ld_addr", imem_addr, 1);
        chk("ld_err", err, 0);

        // Timeout after 15 wait cycles, sticky, start ignored
        do_reset(); run_start(); feed(ALU_A);
        dec_is_mem = 1; step(); dec_is_mem = 0;
        repeat (14) step();
        chk("to_err14", err, 0);
        chk("to_busy14", busy, 1);
        step();
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_req", imem_req, 0);
        start = 1; dmem_ack = 1; step(); clear_in();
        chk("to_sticky", err, 1);
        chk("to_sticky_req", imem_req, 0);

        // Ack on the final counted cycle beats timeout
        do_reset(); run_start(); feed(ALU_A);
        dec_is_mem = 1; step(); dec_is_mem = 0;
        repeat (14) step();
        dmem_ack = 1; step(); dmem_ack = 0;
        chk("ak_err", err, 0);
        chk("ak_req", imem_req, 1);
        chk("ak_addr", imem_addr, 1);

        // Halt and restart
        do_reset(); run_start();
        feed(32'h1); feed(ALU_A); step(); feed(HALTW);
        chk("h_halted", halted, 1);
        chk("h_req", imem_req, 0);
        chk("h_busy", busy, 0);
        chk("h_instr", instr, HALTW);
        chk("h_retired", retired, 1);
        start = 1; step(); start = 0;
        chk("h_restart_halted", halted, 0);
        chk("h_restart_req", imem_req, 1);
        chk("h_restart_addr", imem_addr, 0);
        chk("h_restart_isa", isa_riscv, 0);

        // Reset while a fetch is pending
        do_reset(); run_start(); feed(ALU_A); step();
        repeat (3) step();
        chk("rf_req_held", imem_req, 1);
        rst = 1; imem_ack = 1; imem_data = ALU_C; step(); clear_in();
        chk("rf_req", imem_req, 0);
        chk("rf_busy", busy, 0);
        chk("rf_retired", retired, 0);
        chk("rf_instr", instr, 0);
        chk("rf_addr", imem_addr, 0);

        // Randomized run against the instruction-level model
        for (int a = 0; a < 256; a++) begin
            int r;
            logic [31:0] w;
            r = int'($urandom_range(0, 19));
            w = $urandom;
            if (w == 32'h0 || w == 32'h1 || w == HALTW) w = ALU_A;
            if (r == 0)      w = 32'h0;
            else if (r == 1) w = 32'h1;
            else if (r == 2) w = HALTW;
            prog[a] = w;
        end
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            check_model();
            rst   = (m_phase == P_ERR) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0);
            start = (m_phase == P_IDLE || m_phase == P_HALT) ? ($urandom_range(0, 2) == 0)
                                                             : ($urandom_range(0, 3) == 0);
            imem_ack  = (m_phase == P_FETCH) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            imem_data = (m_phase == P_FETCH) ? prog[m_pc] : $urandom;
            dmem_ack  = (m_phase == P_MEM) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 7) == 0);
            dec_is_mem    = ($urandom_range(0, 3) == 0);
            dec_is_branch = ($urandom_range(0, 2) == 0);
            br_taken      = ($urandom_range(0, 1) == 0);
            br_offset     = 8'($urandom);
            if (rst) begin
                model_reset();
            end else begin
                case (m_phase)
                    P_IDLE: if (start) m_phase = P_FETCH;
                    P_FETCH: if (imem_ack) begin
                        m_instr = imem_data;
                        if (imem_data == 32'h0) begin
                            m_isa = 0; m_pc = m_pc + 8'd1;
                        end else if (imem_data == 32'h1) begin
                            m_isa = 1; m_pc = m_pc + 8'd1;
                        end else if (imem_data == HALTW) begin
                            m_phase = P_HALT;
                        end else begin
                            m_phase = P_ISSUE;
                        end
                    end
                    P_ISSUE: begin
                        m_ret = m_ret + 16'd1;
                        m_phase = P_FETCH;
                        if (dec_is_mem) begin
                            m_phase = P_MEM;
                            m_wait  = 0;
                        end else if (dec_is_branch && br_taken) begin
                            tt   = int'(m_pc) + 1 + int'($signed(br_offset));
                            m_pc = 8'(tt);
                        end else begin
                            m_pc = m_pc + 8'd1;
                        end
                    end
                    P_MEM: begin
                        if (dmem_ack) begin
                            m_pc = m_pc + 8'd1;
                            m_phase = P_FETCH;
                        end else begin
                            m_wait++;
                            if (m_wait == 15) m_phase = P_ERR;
                        end
                    end
                    P_HALT: if (start) begin
                        m_pc = 8'd0; m_isa = 0; m_phase = P_FETCH;
                    end
                    default: ;
                endcase
            end
            step();
        end
        check_model();
        clear_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
